// File: rtl/vga_timing_pkg.sv
// Shared phase encoding, coordinate widths and standard VESA timing sets for the
// VGA timing generator and its per-axis counters.
package vga_timing_pkg;

   localparam int H_W = 11;
   localparam int V_W = 10;

   typedef enum logic [1:0] {
      PH_SYNC,
      PH_BACK,
      PH_ACTIVE,
      PH_FRONT
   } phase_e;

   typedef struct packed {
      logic hs;
      logic vs;
      logic de;
      logic line_start;
      logic frame_start;
   } ctrl_t;

   // 800x600 @ 60 Hz, 40 MHz pixel clock
   localparam int SVGA_H_SYNC = 128, SVGA_H_BACK = 88, SVGA_H_ACTIVE = 800, SVGA_H_FRONT = 40;
   localparam int SVGA_V_SYNC = 4,   SVGA_V_BACK = 23, SVGA_V_ACTIVE = 600, SVGA_V_FRONT = 1;

   // 640x480 @ 60 Hz, 25.175 MHz pixel clock
   localparam int VGA_H_SYNC = 96, VGA_H_BACK = 48, VGA_H_ACTIVE = 640, VGA_H_FRONT = 16;
   localparam int VGA_V_SYNC = 2,  VGA_V_BACK = 33, VGA_V_ACTIVE = 480, VGA_V_FRONT = 10;

   // 1024x768 @ 60 Hz, 65 MHz pixel clock
   localparam int XGA_H_SYNC = 136, XGA_H_BACK = 160, XGA_H_ACTIVE = 1024, XGA_H_FRONT = 24;
   localparam int XGA_V_SYNC = 6,   XGA_V_BACK = 29,  XGA_V_ACTIVE = 768,  XGA_V_FRONT = 3;

   function automatic int cnt_width(input int total);
      return (total < 2) ? 1 : $clog2(total);
   endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: a position counter plus its SYNC/BACK/ACTIVE/FRONT phase machine.
// Exposes next-state values so the top can register outputs with zero lag.
module vga_axis_cnt
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = 1,
   parameter int BACK   = 1,
   parameter int ACTIVE = 1,
   parameter int FRONT  = 1,
   parameter int W      = cnt_width(SYNC + BACK + ACTIVE + FRONT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         step,
   output logic [W-1:0] cnt_d,
   output phase_e       ph_d,
   output logic         wrap,
   output logic         done
);

   localparam logic [W-1:0] END_SYNC   = W'(SYNC - 1);
   localparam logic [W-1:0] END_BACK   = W'(SYNC + BACK - 1);
   localparam logic [W-1:0] END_ACTIVE = W'(SYNC + BACK + ACTIVE - 1);
   localparam logic [W-1:0] LAST       = W'(SYNC + BACK + ACTIVE + FRONT - 1);

   logic [W-1:0] cnt_q;
   phase_e       ph_q;
   logic         ph_end;
   phase_e       ph_next;

   assign wrap = (cnt_q == LAST);
   assign done = step & wrap;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      ph_end  = 1'b0;
      ph_next = ph_q;
      case (ph_q)
         PH_SYNC:   begin ph_end = (cnt_q == END_SYNC);   ph_next = PH_BACK;   end
         PH_BACK:   begin ph_end = (cnt_q == END_BACK);   ph_next = PH_ACTIVE; end
         PH_ACTIVE: begin ph_end = (cnt_q == END_ACTIVE); ph_next = PH_FRONT;  end
         default:   begin ph_end = wrap;                  ph_next = PH_SYNC;   end
      endcase
      if (step) begin
         cnt_d = wrap ? '0 : cnt_q + W'(1);
         if (ph_end) ph_d = ph_next;
      end
   end

   // NOTE: state flops use non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         ph_q  <= PH_SYNC;
      end else begin
         cnt_q <= cnt_d;
         ph_q  <= ph_d;
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA sync/blanking timing generator with registered, zero-lag outputs.
// Define VGA_TIMING_PIPE_EN to delay the sync/de/pulse controls by one extra stage.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC   = SVGA_H_SYNC,
   parameter int H_BACK   = SVGA_H_BACK,
   parameter int H_ACTIVE = SVGA_H_ACTIVE,
   parameter int H_FRONT  = SVGA_H_FRONT,
   parameter int V_SYNC   = SVGA_V_SYNC,
   parameter int V_BACK   = SVGA_V_BACK,
   parameter int V_ACTIVE = SVGA_V_ACTIVE,
   parameter int V_FRONT  = SVGA_V_FRONT,
   parameter bit SYNC_POL = 1'b0
) (
   input  logic           vga_clk,
   input  logic           reset,
   input  logic           timing_en,
   output logic           vga_hs,
   output logic           vga_vs,
   output logic           de,
   output logic [H_W-1:0] pix_x,
   output logic [V_W-1:0] pix_y,
   output logic           line_start,
   output logic           frame_start
);

   localparam int HW = cnt_width(H_SYNC + H_BACK + H_ACTIVE + H_FRONT);
   localparam int VW = cnt_width(V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
   localparam logic [HW-1:0] X0 = HW'(H_SYNC + H_BACK);
   localparam logic [VW-1:0] Y0 = VW'(V_SYNC + V_BACK);
   localparam ctrl_t CTRL_RST = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0,
                                  line_start: 1'b0, frame_start: 1'b0};

   logic           started_q, started_d;
   logic           h_step, h_wrap, h_done, v_wrap, v_done;
   logic [HW-1:0]  h_d;
   logic [VW-1:0]  v_d;
   phase_e         h_ph_d, v_ph_d;
   ctrl_t          ctrl_q, ctrl_d, ctrl_out;
   logic [H_W-1:0] pix_x_q, pix_x_d;
   logic [V_W-1:0] pix_y_q, pix_y_d;

   // The first enabled edge after reset presents (0,0) instead of advancing past it.
   assign h_step = timing_en & started_q;

   vga_axis_cnt #(.SYNC(H_SYNC), .BACK(H_BACK), .ACTIVE(H_ACTIVE), .FRONT(H_FRONT), .W(HW)) u_h_axis (
      .clk(vga_clk), .rst(reset), .step(h_step),
      .cnt_d(h_d), .ph_d(h_ph_d), .wrap(h_wrap), .done(h_done)
   );

   vga_axis_cnt #(.SYNC(V_SYNC), .BACK(V_BACK), .ACTIVE(V_ACTIVE), .FRONT(V_FRONT), .W(VW)) u_v_axis (
      .clk(vga_clk), .rst(reset), .step(h_done),
      .cnt_d(v_d), .ph_d(v_ph_d), .wrap(v_wrap), .done(v_done)
   );

   always_comb begin
      started_d              = started_q | timing_en;
      ctrl_d                 = ctrl_q;
      ctrl_d.line_start      = 1'b0;
      ctrl_d.frame_start     = 1'b0;
      pix_x_d                = pix_x_q;
      pix_y_d                = pix_y_q;
      if (timing_en) begin
         ctrl_d.hs          = (h_ph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         ctrl_d.vs          = (v_ph_d == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
         ctrl_d.de          = (h_ph_d == PH_ACTIVE) && (v_ph_d == PH_ACTIVE);
         ctrl_d.line_start  = ~started_q | h_wrap;
         ctrl_d.frame_start = ~started_q | (v_done & v_wrap);
         pix_x_d            = ctrl_d.de ? H_W'(h_d - X0) : '0;
         pix_y_d            = ctrl_d.de ? V_W'(v_d - Y0) : '0;
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         started_q <= 1'b0;
         ctrl_q    <= CTRL_RST;
         pix_x_q   <= '0;
         pix_y_q   <= '0;
      end else begin
         started_q <= started_d;
         ctrl_q    <= ctrl_d;
         pix_x_q   <= pix_x_d;
         pix_y_q   <= pix_y_d;
      end
   end

`ifdef VGA_TIMING_PIPE_EN
   ctrl_t ctrl_p_q, ctrl_p_d;

   // Controls trail the coordinates by one clock to match a 1-clock character ROM.
   always_comb begin
      ctrl_p_d             = ctrl_p_q;
      ctrl_p_d.line_start  = 1'b0;
      ctrl_p_d.frame_start = 1'b0;
      if (timing_en) ctrl_p_d = ctrl_q;
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) ctrl_p_q <= CTRL_RST;
      else       ctrl_p_q <= ctrl_p_d;
   end

   assign ctrl_out = ctrl_p_q;
`else
   assign ctrl_out = ctrl_q;
`endif

   assign vga_hs      = ctrl_out.hs;
   assign vga_vs      = ctrl_out.vs;
   assign de          = ctrl_out.de;
   assign line_start  = ctrl_out.line_start;
   assign frame_start = ctrl_out.frame_start;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance and a tiny-parameter instance,
// both compared every clock against a position-based reference model.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
   localparam bit PIPE = 1'b1;
`else
   localparam bit PIPE = 1'b0;
`endif

   typedef struct {
      int hs, hb, ha, hf, vs, vb, va, vf;
      bit pol;
   } cfg_t;

   typedef struct {
      int h, v;
      bit started;
      bit hs, vs, de, ls, fs;
      int px, py;
      bit phs, pvs, pde, pls, pfs;
   } mdl_t;

   cfg_t cfg_d = '{hs: 128, hb: 88, ha: 800, hf: 40, vs: 4, vb: 23, va: 600, vf: 1, pol: 1'b0};
   cfg_t cfg_s = '{hs: 2, hb: 2, ha: 4, hf: 2, vs: 1, vb: 1, va: 3, vf: 1, pol: 1'b1};
   mdl_t md, ms;

   logic        clk = 1'b0;
   logic        rst_d, en_d, rst_s, en_s;
   logic        d_hs, d_vs, d_de, d_ls, d_fs, s_hs, s_vs, s_de, s_ls, s_fs;
   logic [10:0] d_px, s_px;
   logic [9:0]  d_py, s_py;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   vga_timing_gen u_dut_d (
      .vga_clk(clk), .reset(rst_d), .timing_en(en_d),
      .vga_hs(d_hs), .vga_vs(d_vs), .de(d_de), .pix_x(d_px), .pix_y(d_py),
      .line_start(d_ls), .frame_start(d_fs)
   );

   vga_timing_gen #(
      .H_SYNC(2), .H_BACK(2), .H_ACTIVE(4), .H_FRONT(2),
      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(3), .V_FRONT(1), .SYNC_POL(1'b1)
   ) u_dut_s (
      .vga_clk(clk), .reset(rst_s), .timing_en(en_s),
      .vga_hs(s_hs), .vga_vs(s_vs), .de(s_de), .pix_x(s_px), .pix_y(s_py),
      .line_start(s_ls), .frame_start(s_fs)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: the raster position advances one pixel per enabled clock; every output
   // is a plain function of the presented (h,v).
   function automatic mdl_t mdl_step(input mdl_t m, input cfg_t c, input bit rst, input bit en);
      mdl_t n = m;
      int htot = c.hs + c.hb + c.ha + c.hf;
      int vtot = c.vs + c.vb + c.va + c.vf;
      int x0 = c.hs + c.hb;
      int y0 = c.vs + c.vb;
      if (rst) begin
         n.h = 0; n.v = 0; n.started = 1'b0;
         n.hs = !c.pol; n.vs = !c.pol; n.de = 0; n.ls = 0; n.fs = 0; n.px = 0; n.py = 0;
         n.phs = !c.pol; n.pvs = !c.pol; n.pde = 0; n.pls = 0; n.pfs = 0;
         return n;
      end
      if (!en) begin
         n.ls = 0; n.fs = 0; n.pls = 0; n.pfs = 0;
         return n;
      end
      n.phs = m.hs; n.pvs = m.vs; n.pde = m.de; n.pls = m.ls; n.pfs = m.fs;
      if (m.started) begin
         n.h = m.h + 1;
         if (n.h == htot) begin
            n.h = 0;
            n.v = (m.v + 1 == vtot) ? 0 : m.v + 1;
         end
      end
      n.started = 1'b1;
      n.hs = (n.h < c.hs) ? c.pol : !c.pol;
      n.vs = (n.v < c.vs) ? c.pol : !c.pol;
      n.de = (n.h >= x0) && (n.h < x0 + c.ha) && (n.v >= y0) && (n.v < y0 + c.va);
      n.px = n.de ? n.h - x0 : 0;
      n.py = n.de ? n.v - y0 : 0;
      n.ls = (n.h == 0);
      n.fs = (n.h == 0) && (n.v == 0);
      return n;
   endfunction

   task automatic cmp(input string p, input mdl_t m, input logic hs, input logic vs, input logic dv,
                      input logic ls, input logic fs, input logic [10:0] px, input logic [9:0] py);
      check({p, ".hs"}, 32'(hs), 32'(PIPE ? m.phs : m.hs));
      check({p, ".vs"}, 32'(vs), 32'(PIPE ? m.pvs : m.vs));
      check({p, ".de"}, 32'(dv), 32'(PIPE ? m.pde : m.de));
      check({p, ".line_start"}, 32'(ls), 32'(PIPE ? m.pls : m.ls));
      check({p, ".frame_start"}, 32'(fs), 32'(PIPE ? m.pfs : m.fs));
      check({p, ".pix_x"}, 32'(px), 32'(m.px));
      check({p, ".pix_y"}, 32'(py), 32'(m.py));
   endtask

   task automatic tick();
      @(posedge clk);
      md = mdl_step(md, cfg_d, rst_d, en_d);
      ms = mdl_step(ms, cfg_s, rst_s, en_s);
      @(negedge clk);
      cmp("d", md, d_hs, d_vs, d_de, d_ls, d_fs, d_px, d_py);
      cmp("s", ms, s_hs, s_vs, s_de, s_ls, s_fs, s_px, s_py);
   endtask

   task automatic tick_rnd_s();
      en_s  = ($urandom_range(3) != 0);
      rst_s = ($urandom_range(96) == 0);
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int fs_cnt, fs_idx0, fs_idx1, vs_cnt, de_rise, hs_lo, de_cnt, de_first, ls_cnt;
      logic prev_de;

      rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
      md = mdl_step(md, cfg_d, 1'b1, 1'b0);
      ms = mdl_step(ms, cfg_s, 1'b1, 1'b0);
      repeat (2) tick();
      check("d.rst_hs", 32'(d_hs), 32'd1);
      check("d.rst_de", 32'(d_de), 32'd0);
      check("s.rst_hs", 32'(s_hs), 32'd0);
      check("s.rst_fs", 32'(s_fs), 32'd0);

      // First enabled edge after release
      rst_d = 1'b0; rst_s = 1'b0; en_d = 1'b1; en_s = 1'b1;
      tick();
      check("d.first_fs", 32'(d_fs), 32'(!PIPE));
      check("d.first_ls", 32'(d_ls), 32'(!PIPE));
      check("d.first_hs", 32'(d_hs), 32'(PIPE));
      check("d.first_vs", 32'(d_vs), 32'(PIPE));
      check("d.first_de", 32'(d_de), 32'd0);
      tick();
      check("d.second_fs", 32'(d_fs), 32'(PIPE));

      // Freeze the small instance at pix_x=2 for 5 clocks
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ms.de && ms.px == 2) found = 1'b1;
         else tick();
      end
      check("s.find_px2", 32'(found), 32'd1);
      en_s = 1'b0;
      repeat (5) begin
         tick();
         check("s.frz_px", 32'(s_px), 32'd2);
         check("s.frz_de", 32'(s_de), 32'd1);
         check("s.frz_ls", 32'(s_ls), 32'd0);
         check("s.frz_fs", 32'(s_fs), 32'd0);
      end
      en_s = 1'b1;
      tick();
      check("s.resume_px", 32'(s_px), 32'd3);

      // Small-instance frame measurement over two frames (60 clocks each)
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (ms.fs) found = 1'b1;
         else tick();
      end
      check("s.find_frame", 32'(found), 32'd1);
      fs_cnt = 0; fs_idx0 = -1; fs_idx1 = -1; vs_cnt = 0; de_rise = 0; prev_de = 1'b0;
      for (int t = 0; t < 120; t++) begin
         if (s_fs) begin
            if (fs_cnt == 0) fs_idx0 = t;
            else if (fs_cnt == 1) fs_idx1 = t;
            fs_cnt++;
         end
         if (t < 60) begin
            if (s_vs == 1'b1) vs_cnt++;
            if (s_de && !prev_de) de_rise++;
         end
         prev_de = s_de;
         tick();
      end
      check("s.fs_count", 32'(fs_cnt), 32'd2);
      check("s.fs_first", 32'(fs_idx0), 32'(PIPE));
      check("s.fs_period", 32'(fs_idx1 - fs_idx0), 32'd60);
      check("s.vs_active_clks", 32'(vs_cnt), 32'd10);
      check("s.de_lines", 32'(de_rise), 32'd3);

      // Default instance: measure the first visible line (v=27)
      found = 1'b0;
      for (int i = 0; i < 40000 && !found; i++) begin
         if (md.h == 0 && md.v == 27) found = 1'b1;
         else tick_rnd_s();
      end
      check("d.find_line27", 32'(found), 32'd1);
      hs_lo = 0; de_cnt = 0; de_first = -1; ls_cnt = 0;
      for (int i = 0; i < 1056; i++) begin
         if (d_hs == 1'b0) hs_lo++;
         if (d_ls) ls_cnt++;
         if (d_de) begin
            de_cnt++;
            if (de_first < 0) de_first = i;
         end
         if (i == 216) check("d.line_px_first", 32'(d_px), 32'd0);
         if (i == 1015) check("d.line_px_last", 32'(d_px), 32'd799);
         tick_rnd_s();
      end
      check("d.hs_low_clks", 32'(hs_lo), 32'd128);
      check("d.de_high_clks", 32'(de_cnt), 32'd800);
      check("d.de_first_h", 32'(de_first), 32'(216 + int'(PIPE)));
      check("d.line_start_cnt", 32'(ls_cnt), 32'd1);

      // Mid-frame asynchronous reset on the default instance at h=500
      found = 1'b0;
      for (int i = 0; i < 2000 && !found; i++) begin
         if (md.h == 500) found = 1'b1;
         else tick_rnd_s();
      end
      check("d.find_h500", 32'(found), 32'd1);
      rst_d = 1'b1;
      #1;
      check("d.arst_hs", 32'(d_hs), 32'd1);
      check("d.arst_vs", 32'(d_vs), 32'd1);
      check("d.arst_de", 32'(d_de), 32'd0);
      check("d.arst_px", 32'(d_px), 32'd0);
      check("d.arst_py", 32'(d_py), 32'd0);
      check("d.arst_ls", 32'(d_ls), 32'd0);
      tick_rnd_s();
      rst_d = 1'b0;
      tick_rnd_s();
      check("d.restart_fs", 32'(d_fs), 32'(!PIPE));
      tick_rnd_s();
      check("d.restart_fs2", 32'(d_fs), 32'(PIPE));

      // Randomized enable and reset on both instances
      for (int i = 0; i < 3000; i++) begin
         en_d  = ($urandom_range(7) != 0);
         rst_d = ($urandom_range(999) == 0);
         tick_rnd_s();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
